// File: rtl/hd_accel_pkg.sv
// Shared types and helpers for the hyperdimensional encoder accumulator lanes.
// Holds the lane FSM encoding, adder-tree depth and the clamping add.
package hd_accel_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic int tree_stages(input int n);
    return $clog2(n);
  endfunction

  // Clamps acc + term into the signed range of a dim_w-bit word (dim_w <= 63).
  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] acc,
    input logic signed [63:0] term,
    input int                 dim_w
  );
    logic signed [64:0] sum;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    sum = 65'(acc) + 65'(term);
    hi  = (65'sd1 <<< (dim_w - 1)) - 65'sd1;
    lo  = -(65'sd1 <<< (dim_w - 1));
    if (sum > hi) begin
      sum = hi;
    end else if (sum < lo) begin
      sum = lo;
    end
    return 64'(sum);
  endfunction

endpackage

// File: rtl/hd_encode_accumulator_if.sv
// Beat input and result output handshake bundle of one accumulator lane.
// master drives beats and out_ready; slave is the accumulator.
interface hd_encode_accumulator_if #(
  parameter int INPUT_NUM   = 32,
  parameter int INPUT_WIDTH = 8,
  parameter int DIM_WIDTH   = 16
);
  logic                                  in_valid;
  logic                                  in_ready;
  logic [INPUT_NUM-1:0][INPUT_WIDTH-1:0] features;
  logic [INPUT_NUM-1:0]                  projections;
  logic signed [DIM_WIDTH-1:0]           bias;
  logic                                  out_valid;
  logic                                  out_ready;
  logic signed [DIM_WIDTH-1:0]           out_sum;
  logic                                  out_bit;

  modport master (
    output in_valid, features, projections, bias, out_ready,
    input  in_ready, out_valid, out_sum, out_bit
  );

  modport slave (
    input  in_valid, features, projections, bias, out_ready,
    output in_ready, out_valid, out_sum, out_bit
  );
endinterface

// File: rtl/hd_signed_adder_tree.sv
// Sign-selects each feature and sums them in S registered pairwise levels.
// Latency S cycles from in_vld to out_vld; no stall, a result emerges every cycle.
module hd_signed_adder_tree import hd_accel_pkg::*; #(
  parameter int  INPUT_NUM   = 32,
  parameter int  INPUT_WIDTH = 8,
  localparam int S           = tree_stages(INPUT_NUM),
  localparam int TREE_W      = INPUT_WIDTH + 1 + S
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_vld,
  input  logic [INPUT_NUM-1:0][INPUT_WIDTH-1:0] features,
  input  logic [INPUT_NUM-1:0]                  projections,
  output logic                                  out_vld,
  output logic signed [TREE_W-1:0]              out_sum
);

  logic signed [INPUT_WIDTH:0] terms [INPUT_NUM];

  always_comb begin
    for (int i = 0; i < INPUT_NUM; i++) begin
      terms[i] = projections[i] ? $signed({1'b0, features[i]})
                                : -$signed({1'b0, features[i]});
    end
  end

  // Each level grows by one bit, so no level can overflow.
  for (genvar l = 1; l <= S; l++) begin : g_lvl
    localparam int N = INPUT_NUM >> l;
    localparam int W = INPUT_WIDTH + 1 + l;
    logic vld;

    for (genvar j = 0; j < N; j++) begin : g_node
      logic signed [W-1:0] a;
      logic signed [W-1:0] b;
      logic signed [W-1:0] sum;

      if (l == 1) begin : g_leaf
        assign a = W'(terms[2*j]);
        assign b = W'(terms[2*j+1]);
      end else begin : g_inner
        assign a = W'(g_lvl[l-1].g_node[2*j].sum);
        assign b = W'(g_lvl[l-1].g_node[2*j+1].sum);
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sum <= '0;
        end else begin
          sum <= a + b;
        end
      end
    end

    if (l == 1) begin : g_vld_first
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld <= 1'b0;
        else       vld <= in_vld;
      end
    end else begin : g_vld_next
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld <= 1'b0;
        else       vld <= g_lvl[l-1].vld;
      end
    end
  end

  assign out_sum = g_lvl[S].g_node[0].sum;
  assign out_vld = g_lvl[S].vld;

endmodule

// File: rtl/hd_encode_accumulator.sv
// One hypervector dimension lane: CHUNKS beats through the adder tree onto a bias.
// Result valid S+1 cycles after the last beat; input stalls until the result is taken.
module hd_encode_accumulator import hd_accel_pkg::*; #(
  parameter int INPUT_NUM   = 32,
  parameter int INPUT_WIDTH = 8,
  parameter int DIM_WIDTH   = 16,
  parameter int CHUNKS      = 4,
  parameter int SATURATE    = 1
) (
  input logic                    clk,
  input logic                    reset,
  hd_encode_accumulator_if.slave bus
);

  localparam int S      = tree_stages(INPUT_NUM);
  localparam int TREE_W = INPUT_WIDTH + 1 + S;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int DRN_W  = $clog2(S + 2);

  state_t                      state;
  state_t                      state_nxt;
  logic [CNT_W-1:0]            beat_cnt;
  logic [DRN_W-1:0]            drain_cnt;
  logic signed [DIM_WIDTH-1:0] acc;
  logic signed [DIM_WIDTH-1:0] acc_nxt;
  logic                        accept;
  logic                        last_beat;
  logic                        tree_vld;
  logic signed [TREE_W-1:0]    tree_sum;

  assign accept    = bus.in_valid && bus.in_ready;
  assign last_beat = accept && (((state == IDLE) && (CHUNKS == 1)) ||
                                ((state == ACCUM) && (beat_cnt == CNT_W'(CHUNKS - 1))));

  hd_signed_adder_tree #(
    .INPUT_NUM   (INPUT_NUM),
    .INPUT_WIDTH (INPUT_WIDTH)
  ) u_tree (
    .clk         (clk),
    .reset       (reset),
    .in_vld      (accept),
    .features    (bus.features),
    .projections (bus.projections),
    .out_vld     (tree_vld),
    .out_sum     (tree_sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_beat ? DRAIN : ACCUM;
      ACCUM:   if (last_beat) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRN_W'(1)) state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE, ACCUM: bus.in_ready  = 1'b1;
      OUT:         bus.out_valid = 1'b1;
      default:     ;
    endcase
  end

  always_comb begin
    if (SATURATE != 0) begin
      acc_nxt = DIM_WIDTH'(sat_add(64'(acc), 64'(tree_sum), DIM_WIDTH));
    end else begin
      acc_nxt = acc + DIM_WIDTH'(tree_sum);
    end
  end

  // The tree is empty whenever IDLE accepts, so bias load never races a tree result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if ((state == IDLE) && accept) begin
        acc      <= bus.bias;
        beat_cnt <= CNT_W'(1);
      end else begin
        if (tree_vld) acc <= acc_nxt;
        if ((state == ACCUM) && accept) beat_cnt <= beat_cnt + CNT_W'(1);
      end
      if (last_beat) begin
        beat_cnt  <= '0;
        drain_cnt <= DRN_W'(S + 1);
      end else if (state == DRAIN) begin
        drain_cnt <= drain_cnt - DRN_W'(1);
      end
    end
  end

  assign bus.out_sum = acc;
  assign bus.out_bit = ~acc[DIM_WIDTH-1];

endmodule

// File: tb/tb_hd_encode_accumulator.sv
// Scoreboard bench for hd_encode_accumulator: a saturating and a wrapping lane
// share one stimulus stream and are checked against a bench-side model.
module tb_hd_encode_accumulator;

  localparam int N   = 32;
  localparam int W   = 8;
  localparam int D   = 16;
  localparam int CH  = 4;
  localparam int LAT = 6;

  typedef logic [N-1:0][W-1:0] feat_t;
  typedef struct {
    int sum_sat;
    int sum_wrap;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  hd_encode_accumulator_if #(.INPUT_NUM(N), .INPUT_WIDTH(W), .DIM_WIDTH(D)) bus ();
  hd_encode_accumulator_if #(.INPUT_NUM(N), .INPUT_WIDTH(W), .DIM_WIDTH(D)) bus_w ();

  assign bus_w.in_valid    = bus.in_valid;
  assign bus_w.features    = bus.features;
  assign bus_w.projections = bus.projections;
  assign bus_w.bias        = bus.bias;
  assign bus_w.out_ready   = bus.out_ready;

  hd_encode_accumulator #(
    .INPUT_NUM(N), .INPUT_WIDTH(W), .DIM_WIDTH(D), .CHUNKS(CH), .SATURATE(1)
  ) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  hd_encode_accumulator #(
    .INPUT_NUM(N), .INPUT_WIDTH(W), .DIM_WIDTH(D), .CHUNKS(CH), .SATURATE(0)
  ) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_w)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int beat_sum(input feat_t f, input logic [N-1:0] p);
    int s = 0;
    for (int i = 0; i < N; i++) begin
      s += p[i] ? int'(f[i]) : -int'(f[i]);
    end
    return s;
  endfunction

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  task automatic send_beat(input feat_t f, input logic [N-1:0] p, input int b);
    int guard = 0;
    bus.features    = f;
    bus.projections = p;
    bus.bias        = 16'(b);
    bus.in_valid    = 1'b1;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk_eq("beat_accept_timeout", guard, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int hold);
    int   lat = 0;
    exp_t e;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk_eq("latency", lat, LAT);
    e = sb.pop_front();
    if (hold > 0) begin
      bus.in_valid = 1'b1;
      for (int h = 0; h < hold; h++) begin
        chk_eq("bp_out_valid", bus.out_valid, 1);
        chk_eq("bp_out_sum", $signed(bus.out_sum), e.sum_sat);
        chk_eq("bp_in_ready", bus.in_ready, 0);
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
    end
    chk_eq("sum_sat", $signed(bus.out_sum), e.sum_sat);
    chk_eq("bit_sat", bus.out_bit, (e.sum_sat >= 0) ? 1 : 0);
    chk_eq("sum_wrap", $signed(bus_w.out_sum), e.sum_wrap);
    chk_eq("bit_wrap", bus_w.out_bit, (e.sum_wrap >= 0) ? 1 : 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk_eq("out_valid_clear", bus.out_valid, 0);
    chk_eq("in_ready_back", bus.in_ready, 1);
  endtask

  task automatic run_vector(input feat_t f, input logic [N-1:0] p, input int bias_v,
                            input int bubble_after, input int hold);
    exp_t e;
    int   bs;
    int   acc;
    bs  = beat_sum(f, p);
    acc = bias_v;
    for (int k = 0; k < CH; k++) begin
      acc += bs;
      if (acc > 32767) acc = 32767;
      else if (acc < -32768) acc = -32768;
    end
    e.sum_sat  = acc;
    e.sum_wrap = wrap16(bias_v + CH * bs);
    sb.push_back(e);
    for (int k = 0; k < CH; k++) begin
      send_beat(f, p, bias_v);
      if (k == bubble_after) @(negedge clk);
    end
    collect(hold);
  endtask

  task automatic check_idle(input string tag);
    chk_eq({tag, "_out_valid"}, bus.out_valid, 0);
    chk_eq({tag, "_in_ready"}, bus.in_ready, 1);
    chk_eq({tag, "_out_sum"}, $signed(bus.out_sum), 0);
    chk_eq({tag, "_out_bit"}, bus.out_bit, 1);
  endtask

  initial begin
    feat_t f_ramp;
    feat_t f_ten;
    feat_t f_max;
    for (int i = 0; i < N; i++) begin
      f_ramp[i] = 8'(i);
      f_ten[i]  = 8'd10;
      f_max[i]  = 8'd255;
    end
    bus.in_valid    = 1'b0;
    bus.features    = '0;
    bus.projections = '0;
    bus.bias        = '0;
    bus.out_ready   = 1'b1;

    repeat (2) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    run_vector(f_ramp, {N{1'b1}}, 3, 1, 0);
    run_vector(f_ten, {{16{1'b1}}, {16{1'b0}}}, -5, -1, 0);
    run_vector(f_max, {N{1'b1}}, 200, -1, 0);

    bus.out_ready = 1'b0;
    run_vector(f_ramp, {N{1'b1}}, 3, -1, 10);

    send_beat(f_max, {N{1'b1}}, 0);
    send_beat(f_max, {N{1'b1}}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle("midreset");
    run_vector(f_ramp, {N{1'b1}}, 3, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
